// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stack_pkg
// Description : Shared constants, operation encoding and count-width helper
//               for the stack_ctrl LIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package stack_pkg;

    localparam int DEFAULT_WIDTH_DATA = 32;
    localparam int DEFAULT_DEPTH      = 16;

    // One decoded operation per cycle; OP_OVF / OP_UNF are ignored requests
    // that only raise the matching sticky error flag.
    typedef enum logic [2:0] {
        OP_NONE    = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_REPLACE = 3'd3,
        OP_OVF     = 3'd4,
        OP_UNF     = 3'd5
    } stack_op_e;

    // Width able to hold every value 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : stack_pkg
`default_nettype wire

// File: rtl/stack_if.sv
`default_nettype none
// ============================================================================
// Module      : stack_if
// Description : Request/status bundle between a stack client (master) and
//               stack_ctrl (slave). Peek signals exist only when the
//               STACK_PEEK_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface stack_if
    import stack_pkg::*;
#(
    parameter int WIDTH_DATA = DEFAULT_WIDTH_DATA,
    parameter int DEPTH      = DEFAULT_DEPTH
);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam int AW    = $clog2(DEPTH);

    logic                  clear;
    logic                  push;
    logic                  pop;
    logic [WIDTH_DATA-1:0] data_in;
    logic [WIDTH_DATA-1:0] data_out;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  overflow;
    logic                  underflow;
`ifdef STACK_PEEK_EN
    logic [AW-1:0]         peek_idx;
    logic [WIDTH_DATA-1:0] peek_data;
    logic                  peek_valid;

    modport master (
        output clear, push, pop, data_in, peek_idx,
        input  data_out, count, full, empty, almost_full, overflow, underflow,
        input  peek_data, peek_valid
    );

    modport slave (
        input  clear, push, pop, data_in, peek_idx,
        output data_out, count, full, empty, almost_full, overflow, underflow,
        output peek_data, peek_valid
    );
`else
    modport master (
        output clear, push, pop, data_in,
        input  data_out, count, full, empty, almost_full, overflow, underflow
    );

    modport slave (
        input  clear, push, pop, data_in,
        output data_out, count, full, empty, almost_full, overflow, underflow
    );
`endif

endinterface : stack_if
`default_nettype wire

// File: rtl/stack_mem.sv
`default_nettype none
// ============================================================================
// Module      : stack_mem
// Description : DEPTH x WIDTH_DATA register array, one synchronous write
//               port and asynchronous read ports (below-top read, plus a
//               peek read when STACK_PEEK_EN is defined). Contents are never
//               reset.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_mem #(
    parameter int WIDTH_DATA = 32,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  wire logic                  clk,
    input  wire logic                  i_we,
    input  wire logic [AW-1:0]         i_wr_addr,
    input  wire logic [WIDTH_DATA-1:0] i_wr_data,
    input  wire logic [AW-1:0]         i_rd_addr,
    output      logic [WIDTH_DATA-1:0] o_rd_data
`ifdef STACK_PEEK_EN
    ,
    input  wire logic [AW-1:0]         i_pk_addr,
    output      logic [WIDTH_DATA-1:0] o_pk_data
`endif
);

    logic [WIDTH_DATA-1:0] r_mem [DEPTH];

    // Single write port; no reset so the array maps onto plain storage.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

`ifdef STACK_PEEK_EN
    assign o_pk_data = r_mem[i_pk_addr];
`endif

endmodule : stack_mem
`default_nettype wire

// File: rtl/stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stack_ctrl
// Description : Parametrised LIFO stack with replace-top (push+pop),
//               occupancy count, almost-full, sticky overflow/underflow and
//               synchronous clear. Define STACK_PEEK_EN to add the indexed
//               peek port.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int WIDTH_DATA  = DEFAULT_WIDTH_DATA,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int AFULL_LEVEL = DEPTH - 2
) (
    input wire logic clk,
    input wire logic reset,
    stack_if.slave   bus
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int AW    = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_two   = CNT_W'(2);
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_afull = CNT_W'(AFULL_LEVEL);

    logic [CNT_W-1:0]      r_sp;
    logic [WIDTH_DATA-1:0] r_data_out;
    logic                  r_overflow;
    logic                  r_underflow;

    stack_op_e             w_op;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_we;
    logic [CNT_W-1:0]      w_wr_ptr;
    logic [CNT_W-1:0]      w_rd_ptr;
    logic [WIDTH_DATA-1:0] w_rd_data;

    assign w_full  = (r_sp == c_depth);
    assign w_empty = (r_sp == '0);

    // Decode the request into exactly one operation for this cycle.
    always_comb begin
        w_op = OP_NONE;
        if (bus.push && bus.pop) begin
            w_op = w_empty ? OP_PUSH : OP_REPLACE;
        end else if (bus.push) begin
            w_op = w_full ? OP_OVF : OP_PUSH;
        end else if (bus.pop) begin
            w_op = w_empty ? OP_UNF : OP_POP;
        end
    end

    // Push writes the free slot, replace overwrites the current top; reset
    // and clear take priority so they suppress the write too.
    assign w_we     = ((w_op == OP_PUSH) || (w_op == OP_REPLACE)) && !reset && !bus.clear;
    assign w_wr_ptr = (w_op == OP_PUSH) ? r_sp : (r_sp - c_one);
    // Entry that becomes the new top after a pop.
    assign w_rd_ptr = r_sp - c_two;

`ifdef STACK_PEEK_EN
    logic [CNT_W-1:0]      w_pk_ext;
    logic [CNT_W-1:0]      w_pk_ptr;
    logic [WIDTH_DATA-1:0] w_pk_raw;
    logic                  w_pk_valid;

    assign w_pk_ext   = CNT_W'(bus.peek_idx);
    assign w_pk_ptr   = r_sp - c_one - w_pk_ext;
    assign w_pk_valid = (w_pk_ext < r_sp);
`endif

    stack_mem #(
        .WIDTH_DATA (WIDTH_DATA),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk       (clk),
        .i_we      (w_we),
        .i_wr_addr (AW'(w_wr_ptr)),
        .i_wr_data (bus.data_in),
        .i_rd_addr (AW'(w_rd_ptr)),
        .o_rd_data (w_rd_data)
`ifdef STACK_PEEK_EN
        ,
        .i_pk_addr (AW'(w_pk_ptr)),
        .o_pk_data (w_pk_raw)
`endif
    );

    // Stack pointer, registered top-of-stack and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            r_sp        <= '0;
            r_data_out  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            case (w_op)
                OP_PUSH: begin
                    r_sp       <= r_sp + c_one;
                    r_data_out <= bus.data_in;
                end
                OP_POP: begin
                    r_sp       <= r_sp - c_one;
                    r_data_out <= (r_sp == c_one) ? '0 : w_rd_data;
                end
                OP_REPLACE: begin
                    r_data_out <= bus.data_in;
                end
                OP_OVF: begin
                    r_overflow <= 1'b1;
                end
                OP_UNF: begin
                    r_underflow <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.data_out    = r_data_out;
    assign bus.count       = r_sp;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.almost_full = (r_sp >= c_afull);
    assign bus.overflow    = r_overflow;
    assign bus.underflow   = r_underflow;

`ifdef STACK_PEEK_EN
    assign bus.peek_valid = w_pk_valid;
    assign bus.peek_data  = w_pk_valid ? w_pk_raw : '0;
`endif

endmodule : stack_ctrl
`default_nettype wire

// File: tb/tb_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_ctrl
// Description : Directed self-checking bench for stack_ctrl (DEPTH=16,
//               WIDTH_DATA=32). Peek scenario runs when STACK_PEEK_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    stack_if #(.WIDTH_DATA(32), .DEPTH(16)) bus ();

    stack_ctrl #(.WIDTH_DATA(32), .DEPTH(16), .AFULL_LEVEL(14)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one request for one clock, then sample 1 time unit after the edge.
    task automatic cyc(input logic p, input logic q, input logic [31:0] d);
        bus.push    = p;
        bus.pop     = q;
        bus.data_in = d;
        @(posedge clk);
        #1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        reset = 1'b0;
        checks++; if (bus.count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.data_out !== 32'd0) begin failures++; $display("FAIL reset_dout got=%0d exp=0", bus.data_out); end
        checks++; if ({bus.empty, bus.full, bus.almost_full} !== 3'b100) begin failures++; $display("FAIL reset_flags got=%b exp=100", {bus.empty, bus.full, bus.almost_full}); end
        checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", {bus.overflow, bus.underflow}); end
    endtask

    task automatic test_push();
        for (int i = 1; i <= 10; i++) cyc(1, 0, 32'(i));
        checks++; if (bus.count !== 5'd10) begin failures++; $display("FAIL push10_count got=%0d exp=10", bus.count); end
        checks++; if (bus.data_out !== 32'd10) begin failures++; $display("FAIL push10_dout got=%0d exp=10", bus.data_out); end
        checks++; if ({bus.almost_full, bus.empty} !== 2'b00) begin failures++; $display("FAIL push10_flags got=%b exp=00", {bus.almost_full, bus.empty}); end
        for (int i = 11; i <= 13; i++) cyc(1, 0, 32'(i));
        checks++; if (bus.almost_full !== 1'b0) begin failures++; $display("FAIL afull_13 got=%b exp=0", bus.almost_full); end
        cyc(1, 0, 32'd14);
        checks++; if (bus.almost_full !== 1'b1) begin failures++; $display("FAIL afull_14 got=%b exp=1", bus.almost_full); end
    endtask

    task automatic test_full_overflow();
        cyc(1, 0, 32'd15);
        cyc(1, 0, 32'd16);
        checks++; if ({bus.full, bus.count} !== {1'b1, 5'd16}) begin failures++; $display("FAIL full_16 got=%b/%0d exp=1/16", bus.full, bus.count); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL full_no_ovf got=%b exp=0", bus.overflow); end
        cyc(1, 0, 32'd99);
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", bus.overflow); end
        checks++; if ({bus.data_out, bus.count} !== {32'd16, 5'd16}) begin failures++; $display("FAIL ovf_state got=%0d/%0d exp=16/16", bus.data_out, bus.count); end
        cyc(1, 1, 32'd77);
        checks++; if ({bus.data_out, bus.count} !== {32'd77, 5'd16}) begin failures++; $display("FAIL repl_full got=%0d/%0d exp=77/16", bus.data_out, bus.count); end
        checks++; if ({bus.overflow, bus.underflow} !== 2'b10) begin failures++; $display("FAIL repl_err got=%b exp=10", {bus.overflow, bus.underflow}); end
        cyc(0, 1, 0);
        checks++; if ({bus.data_out, bus.count, bus.full} !== {32'd15, 5'd15, 1'b0}) begin failures++; $display("FAIL pop_after_full got=%0d/%0d/%b exp=15/15/0", bus.data_out, bus.count, bus.full); end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 9; i++) cyc(0, 1, 0);
        checks++; if ({bus.data_out, bus.count} !== {32'd6, 5'd6}) begin failures++; $display("FAIL pop_to6 got=%0d/%0d exp=6/6", bus.data_out, bus.count); end
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
        bus.clear = 1'b1;
        cyc(1, 0, 32'd55);
        bus.clear = 1'b0;
        checks++; if ({bus.count, bus.data_out} !== {5'd0, 32'd0}) begin failures++; $display("FAIL clear_state got=%0d/%0d exp=0/0", bus.count, bus.data_out); end
        checks++; if ({bus.overflow, bus.empty} !== 2'b01) begin failures++; $display("FAIL clear_flags got=%b exp=01", {bus.overflow, bus.empty}); end
    endtask

    task automatic test_pop_underflow();
        cyc(1, 0, 32'd1);
        cyc(1, 0, 32'd2);
        cyc(1, 0, 32'd3);
        checks++; if (bus.data_out !== 32'd3) begin failures++; $display("FAIL pop_pre got=%0d exp=3", bus.data_out); end
        cyc(0, 1, 0);
        checks++; if ({bus.data_out, bus.count} !== {32'd2, 5'd2}) begin failures++; $display("FAIL pop1 got=%0d/%0d exp=2/2", bus.data_out, bus.count); end
        cyc(0, 1, 0);
        checks++; if ({bus.data_out, bus.count} !== {32'd1, 5'd1}) begin failures++; $display("FAIL pop2 got=%0d/%0d exp=1/1", bus.data_out, bus.count); end
        cyc(0, 1, 0);
        checks++; if ({bus.data_out, bus.empty} !== {32'd0, 1'b1}) begin failures++; $display("FAIL pop3 got=%0d/%b exp=0/1", bus.data_out, bus.empty); end
        cyc(0, 1, 0);
        checks++; if ({bus.underflow, bus.count} !== {1'b1, 5'd0}) begin failures++; $display("FAIL unf got=%b/%0d exp=1/0", bus.underflow, bus.count); end
    endtask

    task automatic test_replace_empty();
        bus.clear = 1'b1;
        cyc(0, 0, 0);
        bus.clear = 1'b0;
        cyc(1, 1, 32'd5);
        checks++; if ({bus.count, bus.data_out} !== {5'd1, 32'd5}) begin failures++; $display("FAIL pp_empty got=%0d/%0d exp=1/5", bus.count, bus.data_out); end
        checks++; if (bus.underflow !== 1'b0) begin failures++; $display("FAIL pp_empty_unf got=%b exp=0", bus.underflow); end
    endtask

    task automatic test_back_to_back();
        bus.clear = 1'b1;
        cyc(0, 0, 0);
        bus.clear = 1'b0;
        cyc(1, 0, 32'd10);
        cyc(1, 0, 32'd20);
        cyc(0, 1, 0);
        cyc(1, 0, 32'd30);
        checks++; if ({bus.data_out, bus.count} !== {32'd30, 5'd2}) begin failures++; $display("FAIL b2b_push got=%0d/%0d exp=30/2", bus.data_out, bus.count); end
        cyc(0, 1, 0);
        checks++; if ({bus.data_out, bus.count} !== {32'd10, 5'd1}) begin failures++; $display("FAIL b2b_pop got=%0d/%0d exp=10/1", bus.data_out, bus.count); end
    endtask

`ifdef STACK_PEEK_EN
    task automatic test_peek();
        logic [31:0] pk_exp [5];
        pk_exp = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        bus.clear = 1'b1;
        cyc(0, 0, 0);
        bus.clear = 1'b0;
        for (int i = 1; i <= 4; i++) cyc(1, 0, 32'(i));
        for (int i = 0; i < 5; i++) begin
            bus.peek_idx = 4'(i);
            #1;
            checks++; if (bus.peek_data !== pk_exp[i]) begin failures++; $display("FAIL peek_data[%0d] got=%0d exp=%0d", i, bus.peek_data, pk_exp[i]); end
            checks++; if (bus.peek_valid !== (i < 4)) begin failures++; $display("FAIL peek_valid[%0d] got=%b exp=%b", i, bus.peek_valid, (i < 4)); end
        end
        bus.peek_idx = '0;
    endtask
`endif

    task automatic test_reset_push();
        cyc(1, 0, 32'd8);
        reset = 1'b1;
        cyc(1, 0, 32'd9);
        reset = 1'b0;
        checks++; if ({bus.count, bus.data_out} !== {5'd0, 32'd0}) begin failures++; $display("FAIL reset_push got=%0d/%0d exp=0/0", bus.count, bus.data_out); end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        bus.clear   = 1'b0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = '0;
`ifdef STACK_PEEK_EN
        bus.peek_idx = '0;
`endif
        test_reset();
        test_push();
        test_full_overflow();
        test_clear();
        test_pop_underflow();
        test_replace_empty();
        test_back_to_back();
`ifdef STACK_PEEK_EN
        test_peek();
`endif
        test_reset_push();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_stack_ctrl
`default_nettype wire
